// File: rtl/dcache_sram_arbiter.sv
// dcache_sram_arbiter
//   Shares one single-port SRAM macro between the core load/store port (a)
//   and the refill port (b). After reset an optional sweep writes zero to
//   every word. The block then arbitrates round-robin between the two
//   request ports and returns one response per accepted request, READ_LAT
//   cycles after the accept.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_*_a / req_*_b       valid/ready request channels (we, addr, wdata, wmask)
//   resp_valid_x/rdata_x    one-cycle response pulse per accepted request
//   csb_o, web_o            SRAM select / write enable (both active-low)
//   wmask_o, addr_o,
//   wdata_o, rdata_i        SRAM byte mask, address, write data, read data
//   init_done_o             high while the controller is in RUN
module dcache_sram_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int READ_LAT   = 1,
  parameter int INIT_ZERO  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  req_valid_a,
  output logic                  req_ready_a,
  input  logic                  req_we_a,
  input  logic [ADDR_WIDTH-1:0] req_addr_a,
  input  logic [DATA_WIDTH-1:0] req_wdata_a,
  input  logic [3:0]            req_wmask_a,

  input  logic                  req_valid_b,
  output logic                  req_ready_b,
  input  logic                  req_we_b,
  input  logic [ADDR_WIDTH-1:0] req_addr_b,
  input  logic [DATA_WIDTH-1:0] req_wdata_b,
  input  logic [3:0]            req_wmask_b,

  output logic                  resp_valid_a,
  output logic [DATA_WIDTH-1:0] resp_rdata_a,
  output logic                  resp_valid_b,
  output logic [DATA_WIDTH-1:0] resp_rdata_b,

  output logic                  csb_o,
  output logic                  web_o,
  output logic [3:0]            wmask_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,

  output logic                  init_done_o
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t              RST_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic                rr_q, rr_d;
  logic                init_act, run_act;
  logic                grant_a, grant_b;

  logic                vld_p  [READ_LAT];
  logic                port_p [READ_LAT];
  logic                we_p   [READ_LAT];

  assign init_act    = (state_q == ST_INIT) && !rst_i;
  assign run_act     = (state_q == ST_RUN)  && !rst_i;
  assign init_done_o = run_act;
  assign req_ready_a = grant_a;
  assign req_ready_b = grant_b;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end

  // accept stage: sweep / arbitration and SRAM command
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    csb_o   = 1'b1;
    web_o   = 1'b1;
    wmask_o = '0;
    addr_o  = '0;
    wdata_o = '0;
    if (init_act) begin
      csb_o   = 1'b0;
      web_o   = 1'b0;
      wmask_o = 4'hF;
      addr_o  = cnt_q[ADDR_WIDTH-1:0];
      cnt_d   = cnt_q + CNT_ONE;
      if (cnt_q == LAST_ADDR) begin
        state_d = ST_RUN;
      end
    end else if (run_act) begin
      grant_a = req_valid_a && (!req_valid_b || !rr_q);
      grant_b = req_valid_b && (!req_valid_a ||  rr_q);
      if (grant_a) begin
        csb_o   = 1'b0;
        web_o   = ~req_we_a;
        wmask_o = req_wmask_a;
        addr_o  = req_addr_a;
        wdata_o = req_wdata_a;
        rr_d    = 1'b1;
      end else if (grant_b) begin
        csb_o   = 1'b0;
        web_o   = ~req_we_b;
        wmask_o = req_wmask_b;
        addr_o  = req_addr_b;
        wdata_o = req_wdata_b;
        rr_d    = 1'b0;
      end
    end
  end

  // in-flight stages 0 .. READ_LAT-1
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < READ_LAT; i++) begin
        vld_p[i]  <= 1'b0;
        port_p[i] <= 1'b0;
        we_p[i]   <= 1'b0;
      end
    end else begin
      vld_p[0]  <= grant_a | grant_b;
      port_p[0] <= grant_b;
      we_p[0]   <= grant_a ? req_we_a : (grant_b & req_we_b);
      for (int i = 1; i < READ_LAT; i++) begin
        vld_p[i]  <= vld_p[i-1];
        port_p[i] <= port_p[i-1];
        we_p[i]   <= we_p[i-1];
      end
    end
  end

  // response stage: SRAM data lines up with the last in-flight stage
  assign resp_valid_a = vld_p[READ_LAT-1] && !port_p[READ_LAT-1];
  assign resp_valid_b = vld_p[READ_LAT-1] &&  port_p[READ_LAT-1];
  assign resp_rdata_a = (resp_valid_a && !we_p[READ_LAT-1]) ? rdata_i : '0;
  assign resp_rdata_b = (resp_valid_b && !we_p[READ_LAT-1]) ? rdata_i : '0;

endmodule

// File: tb/tb_dcache_sram_arbiter.sv
module tb_dcache_sram_arbiter;

  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance: sweep enabled, two-cycle SRAM
  logic          rst;
  logic          va, ra, wea, vb, rb, web_i;
  logic [AW-1:0] adra, adrb;
  logic [DW-1:0] wda, wdb;
  logic [3:0]    ma, mb;
  logic          rva, rvb;
  logic [DW-1:0] rda, rdb;
  logic          csb, web, init_done;
  logic [3:0]    wm;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;

  dcache_sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(LAT), .INIT_ZERO(1)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_a(va), .req_ready_a(ra), .req_we_a(wea), .req_addr_a(adra),
    .req_wdata_a(wda), .req_wmask_a(ma),
    .req_valid_b(vb), .req_ready_b(rb), .req_we_b(web_i), .req_addr_b(adrb),
    .req_wdata_b(wdb), .req_wmask_b(mb),
    .resp_valid_a(rva), .resp_rdata_a(rda), .resp_valid_b(rvb), .resp_rdata_b(rdb),
    .csb_o(csb), .web_o(web), .wmask_o(wm), .addr_o(addr), .wdata_o(wdata),
    .rdata_i(rdata), .init_done_o(init_done)
  );

  // second instance: no sweep, single-cycle SRAM, constant read data
  logic          rst1;
  logic          va1, ra1, wea1, vb1, rb1, web1_i;
  logic [AW-1:0] adra1, adrb1;
  logic [DW-1:0] wda1, wdb1;
  logic [3:0]    ma1, mb1;
  logic          rva1, rvb1;
  logic [DW-1:0] rda1, rdb1;
  logic          csb1, web1, init_done1;
  logic [3:0]    wm1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic [DW-1:0] rd1 = 32'h1357_9BDF;
  logic          d1_done = 1'b0;

  dcache_sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(1), .INIT_ZERO(0)) u_dut1 (
    .clk_i(clk), .rst_i(rst1),
    .req_valid_a(va1), .req_ready_a(ra1), .req_we_a(wea1), .req_addr_a(adra1),
    .req_wdata_a(wda1), .req_wmask_a(ma1),
    .req_valid_b(vb1), .req_ready_b(rb1), .req_we_b(web1_i), .req_addr_b(adrb1),
    .req_wdata_b(wdb1), .req_wmask_b(mb1),
    .resp_valid_a(rva1), .resp_rdata_a(rda1), .resp_valid_b(rvb1), .resp_rdata_b(rdb1),
    .csb_o(csb1), .web_o(web1), .wmask_o(wm1), .addr_o(addr1), .wdata_o(wdata1),
    .rdata_i(rd1), .init_done_o(init_done1)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SRAM macro behaviour: byte-masked write, read data after LAT cycles
  logic [DW-1:0] mem [16];
  logic [DW-1:0] rd_s0, rd_s1, sram_nw;
  always @(posedge clk) begin
    if (!csb) begin
      if (!web) begin
        sram_nw = mem[addr];
        for (int i = 0; i < 4; i++) if (wm[i]) sram_nw[i*8 +: 8] = wdata[i*8 +: 8];
        mem[addr] <= sram_nw;
      end else begin
        rd_s0 <= mem[addr];
      end
    end
    rd_s1 <= rd_s0;
  end
  assign rdata = rd_s1;

  // reference model: memory image, last-granted port, expected responses
  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic [DW-1:0] ref_mem [16];
  logic          last_b;
  exp_t          qa[$];
  exp_t          qb[$];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    last_b = 1'b1;
    qa.delete();
    qb.delete();
  endtask

  task automatic drive_cycle(input logic v_a, input logic w_a, input logic [AW-1:0] ad_a,
                             input logic [DW-1:0] d_a, input logic [3:0] m_a,
                             input logic v_b, input logic w_b, input logic [AW-1:0] ad_b,
                             input logic [DW-1:0] d_b, input logic [3:0] m_b);
    logic          ga, gb, w;
    logic [AW-1:0] ad;
    logic [DW-1:0] d;
    logic [3:0]    m;
    exp_t          e;
    va = v_a; wea = w_a; adra = ad_a; wda = d_a; ma = m_a;
    vb = v_b; web_i = w_b; adrb = ad_b; wdb = d_b; mb = m_b;
    @(negedge clk);
    // contended: the port that did not win last time goes first
    ga = v_a && (!v_b || last_b);
    gb = v_b && (!v_a || !last_b);
    chk("ready_ab", {ra, rb}, {ga, gb});
    chk("init_done_run", init_done, 1'b1);
    if (ga || gb) begin
      w  = ga ? w_a  : w_b;
      ad = ga ? ad_a : ad_b;
      d  = ga ? d_a  : d_b;
      m  = ga ? m_a  : m_b;
      chk("sram_cmd", {csb, web, wm, addr, wdata}, {1'b0, ~w, m, ad, d});
      e.due  = cyc + LAT;
      e.data = w ? 32'h0 : ref_mem[ad];
      if (w) for (int i = 0; i < 4; i++) if (m[i]) ref_mem[ad][i*8 +: 8] = d[i*8 +: 8];
      if (ga) qa.push_back(e); else qb.push_back(e);
      last_b = gb;
    end else begin
      chk("sram_idle", {csb, web, wm, addr, wdata}, {1'b1, 1'b1, 4'h0, {AW{1'b0}}, 32'h0});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) drive_cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic random_cycles(input int n);
    for (int k = 0; k < n; k++)
      drive_cycle(($urandom_range(0, 99) < 65), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                  DW'($urandom), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 99) < 65), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                  DW'($urandom), 4'($urandom_range(0, 15)));
  endtask

  // asserts reset for one cycle with requests pending, checks idle outputs
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    va = 1'b1; vb = 1'b1; wea = 1'b1; web_i = 1'b0;
    @(negedge clk);
    chk("rst_ctrl", {ra, rb, rva, rvb, csb, web, init_done, wm, addr},
        {4'b0000, 1'b1, 1'b1, 1'b0, 4'h0, {AW{1'b0}}});
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_rdata", {rda, rdb}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic sweep(input int n);
    logic [AW-1:0] ia;
    for (int i = 0; i < n; i++) begin
      ia = AW'(i);
      va = 1'b1; vb = 1'b1; wea = 1'b1; adra = ~ia; wda = 32'hFFFF_FFFF; ma = 4'hF;
      web_i = 1'b0; adrb = ia;
      @(negedge clk);
      chk("init_sram", {csb, web, wm, addr, wdata}, {1'b0, 1'b0, 4'hF, ia, 32'h0});
      chk("init_ready", {ra, rb, init_done}, 3'b000);
      chk("init_no_resp", {rva, rvb}, 2'b00);
      @(posedge clk); #1;
    end
  endtask

  task automatic mon(input bit pb, input logic v, input logic [31:0] d);
    exp_t e;
    int   sz;
    sz = pb ? qb.size() : qa.size();
    if (v) begin
      if (sz == 0) begin
        chk(pb ? "resp_b_unexpected" : "resp_a_unexpected", v, 1'b0);
      end else begin
        if (pb) e = qb.pop_front(); else e = qa.pop_front();
        chk(pb ? "resp_b_cycle" : "resp_a_cycle", cyc, e.due);
        chk(pb ? "resp_b_data" : "resp_a_data", d, e.data);
      end
    end else begin
      chk(pb ? "rdata_b_idle" : "rdata_a_idle", d, 32'h0);
      if (sz > 0) begin
        if (pb) e = qb[0]; else e = qa[0];
        if (e.due <= cyc) begin
          chk(pb ? "resp_b_missing" : "resp_a_missing", v, 1'b1);
          if (pb) void'(qb.pop_front()); else void'(qa.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(1'b0, rva, rda);
      mon(1'b1, rvb, rdb);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    model_reset();
    va = 0; wea = 0; adra = '0; wda = '0; ma = '0;
    vb = 0; web_i = 0; adrb = '0; wdb = '0; mb = '0;
    @(posedge clk); #1;
    do_reset();
    sweep(16);
    // both ports contend for four cycles: a, b, a, b
    repeat (4) drive_cycle(1'b1, 1'b0, 4'd1, '0, 4'h0, 1'b1, 1'b0, 4'd2, '0, 4'h0);
    // partial-mask write from b, read back on a
    drive_cycle(1'b0, 1'b0, '0, '0, 4'h0, 1'b1, 1'b1, 4'd7, 32'h1122_3344, 4'b0011);
    drive_cycle(1'b1, 1'b0, 4'd7, '0, 4'h0, 1'b0, 1'b0, '0, '0, 4'h0);
    // full write and read back on a
    drive_cycle(1'b1, 1'b1, 4'd5, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, '0, '0, 4'h0);
    drive_cycle(1'b1, 1'b0, 4'd5, '0, 4'h0, 1'b0, 1'b0, '0, '0, 4'h0);
    idle_cycles(4);
    random_cycles(400);
    idle_cycles(LAT + 2);
    chk("drain_1", qa.size() + qb.size(), 0);
    // read in flight when reset hits: its response must never appear
    drive_cycle(1'b1, 1'b0, 4'd5, '0, 4'h0, 1'b0, 1'b0, '0, '0, 4'h0);
    do_reset();
    sweep(5);
    do_reset();
    sweep(16);
    random_cycles(150);
    idle_cycles(LAT + 2);
    chk("drain_2", qa.size() + qb.size(), 0);
    chk("d1_finished", d1_done, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    rst1 = 1'b1;
    va1 = 1'b1; wea1 = 1'b0; adra1 = '0; wda1 = '0; ma1 = '0;
    vb1 = 1'b0; web1_i = 1'b0; adrb1 = '0; wdb1 = '0; mb1 = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("d1_rst_ctrl", {ra1, rb1, rva1, rvb1, csb1, web1, init_done1, wm1, addr1},
        {4'b0000, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0});
    chk("d1_rst_data", {rda1, rdb1}, 64'h0);
    @(posedge clk); #1;
    rst1 = 1'b0;
    va1 = 1'b1; wea1 = 1'b1; adra1 = 4'd3; wda1 = 32'hA5A5_5A5A; ma1 = 4'b1010;
    @(negedge clk);
    chk("d1_ready_first", {ra1, rb1}, 2'b10);
    chk("d1_init_done", init_done1, 1'b1);
    chk("d1_sram_wr", {csb1, web1, wm1, addr1, wdata1}, {1'b0, 1'b0, 4'b1010, 4'd3, 32'hA5A5_5A5A});
    @(posedge clk); #1;
    wea1 = 1'b0; adra1 = 4'd9;
    @(negedge clk);
    chk("d1_wr_resp", {rva1, rda1}, {1'b1, 32'h0});
    chk("d1_sram_rd", {csb1, web1, wm1, addr1, wdata1}, {1'b0, 1'b1, 4'b1010, 4'd9, 32'hA5A5_5A5A});
    @(posedge clk); #1;
    va1 = 1'b0; vb1 = 1'b1; adrb1 = 4'd2;
    @(negedge clk);
    chk("d1_rd_resp_a", {rva1, rda1}, {1'b1, 32'h1357_9BDF});
    chk("d1_ready_b", {ra1, rb1}, 2'b01);
    @(posedge clk); #1;
    va1 = 1'b1; adra1 = 4'd4; adrb1 = 4'd6;
    @(negedge clk);
    chk("d1_rd_resp_b", {rvb1, rdb1, rva1}, {1'b1, 32'h1357_9BDF, 1'b0});
    chk("d1_contend_1", {ra1, rb1}, 2'b10);
    @(posedge clk); #1;
    @(negedge clk);
    chk("d1_contend_2", {ra1, rb1}, 2'b01);
    chk("d1_resp_a_2", {rva1, rvb1, rda1}, {2'b10, 32'h1357_9BDF});
    @(posedge clk); #1;
    va1 = 1'b0; vb1 = 1'b0;
    @(negedge clk);
    chk("d1_idle_sram", {csb1, web1, wm1, addr1, wdata1}, {1'b1, 1'b1, 4'h0, 4'h0, 32'h0});
    chk("d1_resp_b_2", {rva1, rvb1, rdb1}, {2'b01, 32'h1357_9BDF});
    @(posedge clk); #1;
    @(negedge clk);
    chk("d1_quiet", {rva1, rvb1, rda1, rdb1}, {2'b00, 64'h0});
    d1_done = 1'b1;
  end

endmodule
